ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage MIPS pipeline, directly downstream of ID. Registers the
//  ID->EX bus, runs the 12-op ALU, issues the data-SRAM request, and forwards its
//  writeback triple to ID. Owns HI/LO and a multi-cycle iterative divider that stalls
//  the pipeline through stallreq_for_ex.
// PARAMETERS
//  ID_TO_EX_WD   159  ID bus: pc[158:127] inst[126:95] alu_op[94:83] src1[82:80] src2[79:76]
//                     ram_en[75] ram_wen[74:71] rf_we[70] rf_waddr[69:65] sel_rf_res[64]
//                     rdata1[63:32] rdata2[31:0]
//  EX_TO_MEM_WD  76   {pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38], rf_we[37],
//                     rf_waddr[36:32], result[31:0]}
//  STALL_WD      6    stall vector width; bit 2 = EX, bit 3 = MEM
// PORTS
//  clk              in   1    clock
//  rst              in   1    reset; synchronous, active-high
//  stall            in   6    per-stage stall from the stall controller
//  id_to_ex_bus     in   159  decoded instruction and operands from ID
//  ex_to_mem_bus    out  76   to the MEM pipeline register
//  ex_to_rf_bus     out  38   {rf_we, rf_waddr, result} forwarding path to ID
//  data_sram_en     out  1    data RAM access enable
//  data_sram_wen    out  4    byte write enables
//  data_sram_addr   out  32   byte address
//  data_sram_wdata  out  32   store data
//  stallreq_for_ex  out  1    hold IF/ID/EX while the divider runs
// BEHAVIOUR
//  Pipeline register (synchronous):
//   - rst, or stall[2]=Stop with stall[3]=NoStop: load all-zero (bubble; rf_we=0, ram_en=0).
//   - stall[2]=NoStop: load id_to_ex_bus.
//   - Otherwise hold.
//  ALU (combinational from the register):
//   - src1 = sa zero-extended, pc, or rs, selected by one-hot src1[2:0].
//   - src2 = zero-ext imm, 32'd8, sign-ext imm, or rt, selected by src2[3:0].
//   - alu_op is one-hot {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}.
//   - Shifts use src1[4:0]. lui = {imm,16'b0}. Add/sub wrap modulo 2^32; no overflow trap.
//   - All-zero alu_op gives result 0.
//  Memory request:
//   - data_sram_en = ram_en; wen = ram_wen; addr = ALU result (rs + sext imm); wdata = rdata2.
//  Result mux: MFHI (op 0, func 0x10) -> HI; MFLO (func 0x12) -> LO; otherwise ALU.
//   - MTHI/MTLO (func 0x11/0x13) write rdata1 to HI/LO at the clock edge.
//  ex_to_rf_bus and ex_to_mem_bus update in the same cycle as the register.
//   - Both carry rf_we=0 during a bubble.
//  Reset values: every output 0; HI=LO=0; divider FSM in IDLE.
// CONFIGURATION
//  EX_DIV_EN defined: DIV (func 0x1A) and DIVU (0x1B) run on a restoring divider.
//   - FSM states: IDLE -> RUN (div in EX, register loaded) -> DONE -> IDLE.
//   - RUN: 32 iterations, one quotient bit per cycle, 5-bit counter 0..31.
//   - DONE: LO = quotient, HI = remainder written at the clock edge. FSM returns to
//     IDLE when stall[2]=NoStop.
//   - stallreq_for_ex is high (combinational) in the IDLE cycle that sees the div and
//     throughout RUN; it is low in DONE. Total 33 stall cycles.
//   - Signed: divide magnitudes. Negate quotient if signs differ; remainder takes the
//     dividend's sign.
//   - Divide by zero: no trap. LO=32'hFFFFFFFF, HI=dividend; same latency.
//   - rst mid-divide: FSM to IDLE, HI/LO cleared, stallreq low next cycle.
//  EX_DIV_EN undefined: DIV/DIVU are no-ops (HI/LO unchanged); stallreq_for_ex tied 0;
//   no divider logic.
// TESTING
//  1. ori $1,$0,0x00FF after reset -> result 32'h000000FF, rf_we=1, waddr=1, forwarded
//     in the same cycle.
//  2. sw: rs=0x1000, imm=-4 -> data_sram_en=1, wen=4'hF, addr=32'h00000FFC,
//     wdata=rdata2.
//  3. stall[2]=Stop, stall[3]=NoStop for 1 cycle -> ex_to_mem_bus all-zero for one cycle,
//     then the held instruction reappears.
//  4. [EX_DIV_EN] DIVU 100/7 -> stallreq high 33 cycles; then MFLO=14, MFHI=2.
//     DIV -7/2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
//  5. [EX_DIV_EN] DIV 5/0 -> LO=32'hFFFFFFFF, HI=5, 33-cycle stall. rst at RUN cycle 10
//     -> stallreq 0 next cycle, HI=LO=0.
//  6. EX_DIV_EN undefined: DIVU 100/7 -> stallreq stays 0; HI/LO keep prior MTHI/MTLO
//     values.

Source files
------------

// File: rtl/ex_stage_if.sv
// Pipeline buses, stall handshake and data-SRAM request of the MIPS execute stage.
// master = the EX stage itself, slave = its surroundings (ID, MEM, stall controller, SRAM).
interface ex_stage_if #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int STALL_WD     = 6
);
  logic [STALL_WD-1:0]     stall;
  logic                    stallreq_for_ex;
  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [37:0]             ex_to_rf_bus;
  logic                    data_sram_en;
  logic [3:0]              data_sram_wen;
  logic [31:0]             data_sram_addr;
  logic [31:0]             data_sram_wdata;

  modport master (
    input  stall, id_to_ex_bus,
    output stallreq_for_ex, ex_to_mem_bus, ex_to_rf_bus,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

  modport slave (
    output stall, id_to_ex_bus,
    input  stallreq_for_ex, ex_to_mem_bus, ex_to_rf_bus,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: ID->EX register, 12-op ALU, data-SRAM request, HI/LO registers.
// Define EX_DIV_EN to add the restoring divider for DIV/DIVU (33-cycle stall).
module ex_stage (
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.master bus
);
  localparam int ID_TO_EX_WD = 159;

  logic [ID_TO_EX_WD-1:0] id_to_ex_q, id_to_ex_d;

  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  src1_sel;
  logic [3:0]  src2_sel, ram_wen;
  logic        ram_en, rf_we, sel_rf_res;
  logic [4:0]  rf_waddr, sa;
  logic [15:0] imm;
  logic [31:0] src1, src2, alu_result, ex_result;
  logic        is_special, is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        stallreq;
  logic        unused_ok;

  // Stop with the next stage running inserts a bubble; stop with it stopped holds.
  always_comb begin
    id_to_ex_d = id_to_ex_q;
    if (!bus.stall[2])
      id_to_ex_d = bus.id_to_ex_bus;
    else if (!bus.stall[3])
      id_to_ex_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) id_to_ex_q <= '0;
    else     id_to_ex_q <= id_to_ex_d;
  end

  assign {pc, inst, alu_op, src1_sel, src2_sel, ram_en, ram_wen, rf_we, rf_waddr,
          sel_rf_res, rdata1, rdata2} = id_to_ex_q;

  assign imm = inst[15:0];
  assign sa  = inst[10:6];

  assign src1 = ({32{src1_sel[2]}} & {27'd0, sa})
              | ({32{src1_sel[1]}} & pc)
              | ({32{src1_sel[0]}} & rdata1);
  assign src2 = ({32{src2_sel[3]}} & {16'd0, imm})
              | ({32{src2_sel[2]}} & 32'd8)
              | ({32{src2_sel[1]}} & {{16{imm[15]}}, imm})
              | ({32{src2_sel[0]}} & rdata2);

  always_comb begin
    alu_result = '0;
    if (alu_op[11]) alu_result = alu_result | (src1 + src2);
    if (alu_op[10]) alu_result = alu_result | (src1 - src2);
    if (alu_op[9])  alu_result = alu_result | {31'd0, $signed(src1) < $signed(src2)};
    if (alu_op[8])  alu_result = alu_result | {31'd0, src1 < src2};
    if (alu_op[7])  alu_result = alu_result | (src1 & src2);
    if (alu_op[6])  alu_result = alu_result | ~(src1 | src2);
    if (alu_op[5])  alu_result = alu_result | (src1 | src2);
    if (alu_op[4])  alu_result = alu_result | (src1 ^ src2);
    if (alu_op[3])  alu_result = alu_result | (src2 << src1[4:0]);
    if (alu_op[2])  alu_result = alu_result | (src2 >> src1[4:0]);
    if (alu_op[1])  alu_result = alu_result | $unsigned($signed(src2) >>> src1[4:0]);
    if (alu_op[0])  alu_result = alu_result | {imm, 16'd0};
  end

  assign is_special = (inst[31:26] == 6'd0);
  assign is_mfhi    = is_special && (inst[5:0] == 6'h10);
  assign is_mthi    = is_special && (inst[5:0] == 6'h11);
  assign is_mflo    = is_special && (inst[5:0] == 6'h12);
  assign is_mtlo    = is_special && (inst[5:0] == 6'h13);

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, divisor_q, divisor_d, dividend_q, dividend_d;
  logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, by_zero_q, by_zero_d;
  logic        is_div, is_signed_div, div_wr;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic [31:0] div_hi, div_lo;
  logic        unused_div;

  assign is_div        = is_special && (inst[5:1] == 5'b01101);
  assign is_signed_div = ~inst[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      by_zero_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      divisor_q  <= divisor_d;
      dividend_q <= dividend_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      by_zero_q  <= by_zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (is_div) state_d = DIV_RUN;
      DIV_RUN:  if (cnt_q == 5'd31) state_d = DIV_DONE;
      DIV_DONE: if (!bus.stall[2]) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_comb begin
    stallreq = 1'b0;
    div_wr   = 1'b0;
    case (state_q)
      DIV_IDLE: stallreq = is_div;
      DIV_RUN:  stallreq = 1'b1;
      DIV_DONE: div_wr   = 1'b1;
      default:  stallreq = 1'b0;
    endcase
  end

  // Operands are captured as magnitudes so the register may be bubbled or reloaded mid-divide.
  always_comb begin
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    divisor_d  = divisor_q;
    dividend_d = dividend_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    by_zero_d  = by_zero_q;
    shifted    = {rem_q, quo_q[31]};
    diff       = {1'b0, shifted} - {2'b00, divisor_q};
    if (state_q == DIV_IDLE && is_div) begin
      cnt_d      = '0;
      rem_d      = '0;
      quo_d      = (is_signed_div && rdata1[31]) ? -rdata1 : rdata1;
      divisor_d  = (is_signed_div && rdata2[31]) ? -rdata2 : rdata2;
      dividend_d = rdata1;
      neg_quo_d  = is_signed_div && (rdata1[31] ^ rdata2[31]);
      neg_rem_d  = is_signed_div && rdata1[31];
      by_zero_d  = (rdata2 == 32'd0);
    end else if (state_q == DIV_RUN) begin
      cnt_d = cnt_q + 5'd1;
      if (!diff[33]) begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
    end
  end

  assign div_lo     = by_zero_q ? 32'hFFFF_FFFF : (neg_quo_q ? -quo_q : quo_q);
  assign div_hi     = by_zero_q ? dividend_q    : (neg_rem_q ? -rem_q : rem_q);
  assign unused_div = diff[32];
`else
  assign stallreq = 1'b0;
`endif

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (is_mthi) hi_d = rdata1;
    if (is_mtlo) lo_d = rdata1;
`ifdef EX_DIV_EN
    if (div_wr) begin
      hi_d = div_hi;
      lo_d = div_lo;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    ex_result = alu_result;
    if (is_mfhi)      ex_result = hi_q;
    else if (is_mflo) ex_result = lo_q;
  end

  assign bus.ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
  assign bus.ex_to_rf_bus    = {rf_we, rf_waddr, ex_result};
  assign bus.data_sram_en    = ram_en;
  assign bus.data_sram_wen   = ram_wen;
  assign bus.data_sram_addr  = alu_result;
  assign bus.data_sram_wdata = rdata2;
  assign bus.stallreq_for_ex = stallreq;

  assign unused_ok = ^{bus.stall[5:4], bus.stall[1:0], inst[25:16]};
endmodule

// File: tb/tb_ex_stage.sv
// Directed and randomized checks of ex_stage against a behavioural model of the EX rules.
// Compile with +define+EX_DIV_EN to also exercise DIV/DIVU on the divider.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  ex_stage_if ifc ();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  function automatic logic [158:0] mk_bus(
    input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] aop,
    input logic [2:0] s1, input logic [3:0] s2, input logic ram_en, input logic [3:0] ram_wen,
    input logic rf_we, input logic [4:0] waddr, input logic sel_rf,
    input logic [31:0] r1, input logic [31:0] r2);
    return {pc, inst, aop, s1, s2, ram_en, ram_wen, rf_we, waddr, sel_rf, r1, r2};
  endfunction

  function automatic logic [75:0] exp_mem(
    input logic [31:0] pc, input logic ram_en, input logic [3:0] ram_wen, input logic sel_rf,
    input logic rf_we, input logic [4:0] waddr, input logic [31:0] res);
    return {pc, ram_en, ram_wen, sel_rf, rf_we, waddr, res};
  endfunction

  // Operation index follows the listed order: add sub slt sltu and nor or xor sll srl sra lui.
  function automatic logic [31:0] model_alu(input int op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [15:0] imm);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return b << a[4:0];
      9:  return b >> a[4:0];
      10: return 32'($signed(b) >>> a[4:0]);
      default: return {imm, 16'h0000};
    endcase
  endfunction

  task automatic model_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic applyStimulus(input logic [158:0] b, input logic [5:0] s);
    @(negedge clk);
    ifc.id_to_ex_bus = b;
    ifc.stall        = s;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkHiLo(input string tag);
    logic [31:0]  pc;
    logic [158:0] b;
    pc = $urandom();
    b  = mk_bus(pc, {6'h00, 10'd0, 5'd3, 5'd0, 6'h12}, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0,
                1'b1, 5'd3, 1'b0, $urandom(), $urandom());
    applyStimulus(b, 6'd0);
    checkOutput({tag, "_mflo"}, ifc.ex_to_mem_bus, exp_mem(pc, 1'b0, 4'd0, 1'b0, 1'b1, 5'd3, lo_m));
    pc = $urandom();
    b  = mk_bus(pc, {6'h00, 10'd0, 5'd3, 5'd0, 6'h10}, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0,
                1'b1, 5'd3, 1'b0, $urandom(), $urandom());
    applyStimulus(b, 6'd0);
    checkOutput({tag, "_mfhi"}, ifc.ex_to_mem_bus, exp_mem(pc, 1'b0, 4'd0, 1'b0, 1'b1, 5'd3, hi_m));
  endtask

  function automatic logic [158:0] mk_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    return mk_bus($urandom(), {6'h00, 5'd5, 5'd6, 10'd0, sgn ? 6'h1A : 6'h1B}, 12'd0,
                  3'b001, 4'b0001, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, a, b);
  endfunction

`ifdef EX_DIV_EN
  task automatic runDiv(input logic [158:0] b, output int cyc);
    applyStimulus(b, 6'd0);
    cyc = 0;
    while (ifc.stallreq_for_ex === 1'b1 && cyc < 100) begin
      cyc++;
      applyStimulus(b, 6'b001111);
    end
  endtask
`endif

  initial begin
    logic [158:0] b, x_bus, sw_bus;
    logic [75:0]  x_exp;
    logic [31:0]  pc, inst, r1, r2, a_op, b_op, res, q, r;
    logic [11:0]  aop;
    logic [2:0]   s1;
    logic [3:0]   s2, wen;
    logic         ren, we, sel;
    logic [4:0]   wa;
    int           op_idx, k1, k2, cyc;

    $display("[TB] tb_ex_stage start");
    ifc.stall        = 6'd0;
    ifc.id_to_ex_bus = '0;

    // Reset with a live-looking instruction on the bus: everything must still read zero.
    b = mk_bus($urandom(), $urandom(), 12'h800, 3'b001, 4'b0001, 1'b1, 4'hF, 1'b1, 5'd7,
               1'b1, $urandom(), $urandom());
    applyStimulus(b, 6'd0);
    applyStimulus(b, 6'd0);
    checkOutput("rst_mem_bus", ifc.ex_to_mem_bus, 76'd0);
    checkOutput("rst_rf_bus", 76'(ifc.ex_to_rf_bus), 76'd0);
    checkOutput("rst_sram", 76'({ifc.data_sram_en, ifc.data_sram_wen, ifc.data_sram_addr,
                                 ifc.data_sram_wdata}), 76'd0);
    checkOutput("rst_stallreq", 76'(ifc.stallreq_for_ex), 76'd0);
    rst = 1'b0;

    // ori $1,$0,0x00FF
    pc    = 32'hBFC0_0000;
    x_bus = mk_bus(pc, {6'h0D, 5'd0, 5'd1, 16'h00FF}, 12'h020, 3'b001, 4'b1000, 1'b0, 4'd0,
                   1'b1, 5'd1, 1'b0, 32'd0, 32'h5555_AAAA);
    x_exp = exp_mem(pc, 1'b0, 4'd0, 1'b0, 1'b1, 5'd1, 32'h0000_00FF);
    applyStimulus(x_bus, 6'd0);
    checkOutput("ori_rf_bus", 76'(ifc.ex_to_rf_bus), 76'({1'b1, 5'd1, 32'h0000_00FF}));
    checkOutput("ori_mem_bus", ifc.ex_to_mem_bus, x_exp);

    // sw with rs=0x1000, imm=-4
    sw_bus = mk_bus(32'hBFC0_0004, {6'h2B, 5'd2, 5'd3, 16'hFFFC}, 12'h800, 3'b001, 4'b0010,
                    1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h0000_1000, 32'hCAFE_F00D);
    applyStimulus(sw_bus, 6'd0);
    checkOutput("sw_en_wen", 76'({ifc.data_sram_en, ifc.data_sram_wen}), 76'({1'b1, 4'hF}));
    checkOutput("sw_addr", 76'(ifc.data_sram_addr), 76'(32'h0000_0FFC));
    checkOutput("sw_wdata", 76'(ifc.data_sram_wdata), 76'(32'hCAFE_F00D));

    // Bubble for one cycle, then the held instruction reappears; then a full hold.
    applyStimulus(x_bus, 6'd0);
    checkOutput("pre_bubble", ifc.ex_to_mem_bus, x_exp);
    applyStimulus(x_bus, 6'b000100);
    checkOutput("bubble_mem_bus", ifc.ex_to_mem_bus, 76'd0);
    checkOutput("bubble_rf_bus", 76'(ifc.ex_to_rf_bus), 76'd0);
    applyStimulus(x_bus, 6'd0);
    checkOutput("post_bubble", ifc.ex_to_mem_bus, x_exp);
    applyStimulus(sw_bus, 6'b001100);
    checkOutput("hold", ifc.ex_to_mem_bus, x_exp);

    // MTHI / MTLO then read back
    b = mk_bus($urandom(), {6'h00, 5'd4, 15'd0, 6'h11}, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0,
               5'd0, 1'b0, 32'h1234_5678, $urandom());
    applyStimulus(b, 6'd0);
    hi_m = 32'h1234_5678;
    b = mk_bus($urandom(), {6'h00, 5'd4, 15'd0, 6'h13}, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0,
               5'd0, 1'b0, 32'h9ABC_DEF0, $urandom());
    applyStimulus(b, 6'd0);
    lo_m = 32'h9ABC_DEF0;
    checkHiLo("mt");

    // Random ALU traffic
    for (int i = 0; i < 40; i++) begin
      op_idx = $urandom_range(0, 11);
      k1     = $urandom_range(0, 2);
      k2     = $urandom_range(0, 3);
      pc     = $urandom();
      inst   = {6'($urandom_range(1, 63)), 26'($urandom())};
      r1     = $urandom();
      r2     = $urandom();
      ren    = 1'($urandom());
      wen    = 4'($urandom());
      we     = 1'($urandom());
      wa     = 5'($urandom());
      sel    = 1'($urandom());
      aop    = 12'(1) << (11 - op_idx);
      s1     = 3'(1) << k1;
      s2     = 4'(1) << k2;
      a_op   = (k1 == 0) ? r1 : (k1 == 1) ? pc : {27'd0, inst[10:6]};
      case (k2)
        0:       b_op = r2;
        1:       b_op = {{16{inst[15]}}, inst[15:0]};
        2:       b_op = 32'd8;
        default: b_op = {16'd0, inst[15:0]};
      endcase
      res = model_alu(op_idx, a_op, b_op, inst[15:0]);
      b   = mk_bus(pc, inst, aop, s1, s2, ren, wen, we, wa, sel, r1, r2);
      applyStimulus(b, 6'd0);
      checkOutput("rand_mem_bus", ifc.ex_to_mem_bus, exp_mem(pc, ren, wen, sel, we, wa, res));
      checkOutput("rand_rf_bus", 76'(ifc.ex_to_rf_bus), 76'({we, wa, res}));
      checkOutput("rand_sram", 76'({ifc.data_sram_en, ifc.data_sram_wen, ifc.data_sram_addr,
                                    ifc.data_sram_wdata}), 76'({ren, wen, res, r2}));
    end

`ifdef EX_DIV_EN
    runDiv(mk_div(32'd100, 32'd7, 1'b0), cyc);
    checkOutput("divu_stall_cycles", 76'(cyc), 76'(33));
    model_div(32'd100, 32'd7, 1'b0, q, r);
    lo_m = q;
    hi_m = r;
    checkHiLo("divu_100_7");

    runDiv(mk_div(32'hFFFF_FFF9, 32'd2, 1'b1), cyc);
    checkOutput("div_stall_cycles", 76'(cyc), 76'(33));
    model_div(32'hFFFF_FFF9, 32'd2, 1'b1, q, r);
    lo_m = q;
    hi_m = r;
    checkHiLo("div_m7_2");

    runDiv(mk_div(32'd5, 32'd0, 1'b1), cyc);
    checkOutput("div0_stall_cycles", 76'(cyc), 76'(33));
    model_div(32'd5, 32'd0, 1'b1, q, r);
    lo_m = q;
    hi_m = r;
    checkHiLo("div_5_0");

    for (int i = 0; i < 4; i++) begin
      a_op = $urandom();
      b_op = $urandom() >> $urandom_range(0, 28);
      ren  = 1'(i);
      if (ren && a_op == 32'h8000_0000 && b_op == 32'hFFFF_FFFF) b_op = 32'd3;
      runDiv(mk_div(a_op, b_op, ren), cyc);
      checkOutput("rdiv_stall_cycles", 76'(cyc), 76'(33));
      model_div(a_op, b_op, ren, q, r);
      lo_m = q;
      hi_m = r;
      checkHiLo("rdiv");
    end

    // Reset part-way through RUN
    b = mk_div(32'd1000, 32'd3, 1'b0);
    applyStimulus(b, 6'd0);
    for (int i = 0; i < 10; i++) applyStimulus(b, 6'b001111);
    checkOutput("mid_run_stallreq", 76'(ifc.stallreq_for_ex), 76'd1);
    rst = 1'b1;
    applyStimulus(b, 6'b001111);
    checkOutput("rst_div_stallreq", 76'(ifc.stallreq_for_ex), 76'd0);
    rst  = 1'b0;
    hi_m = '0;
    lo_m = '0;
    checkHiLo("rst_div");
`else
    b = mk_div(32'd100, 32'd7, 1'b0);
    applyStimulus(b, 6'd0);
    checkOutput("nodiv_stallreq0", 76'(ifc.stallreq_for_ex), 76'd0);
    applyStimulus(mk_bus('0, '0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0), 6'd0);
    checkOutput("nodiv_stallreq1", 76'(ifc.stallreq_for_ex), 76'd0);
    checkHiLo("nodiv");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
